// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the synchronous register file.
//   DATA_W_DEF/ADDR_W_DEF/NUM_RD_DEF  default geometry
//   DEPTH_DEF                         entries derived from address width
//   ZERO_REG                          1 when REGFILE_ZERO_REG_EN is defined (entry 0 hardwired to 0)
package regfile_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 3;
  localparam int NUM_RD_DEF = 2;
  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction
  localparam int DEPTH_DEF = depth_of(ADDR_W_DEF);
  typedef logic [DATA_W_DEF-1:0] data_t;
  typedef logic [ADDR_W_DEF-1:0] addr_t;
`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: one registered read port with write-first bypass and zero-reg masking.
//   clk, rst        clock, synchronous active-high reset
//   rd_addr_i       entry selected by this port
//   wr_en_i         effective write strobe (already suppressed for a hardwired entry 0)
//   wr_addr_i/wr_data_i  write port, used for same-edge bypass
//   mem_data_i      stored word at rd_addr_i
//   busy_nxt_i      post-update busy bit of rd_addr_i
//   rd_data_o/rd_busy_o  registered outputs
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              busy_nxt_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_busy_o
);
  logic              zero_hit;
  logic [DATA_W-1:0] rd_data_d, rd_data_q;
  logic              rd_busy_d, rd_busy_q;
  assign zero_hit = ZERO_REG && (rd_addr_i == '0);
  always_comb begin
    rd_data_d = zero_hit ? '0 : (wr_en_i && wr_addr_i == rd_addr_i) ? wr_data_i : mem_data_i;
    rd_busy_d = !zero_hit && busy_nxt_i;
  end
  always_ff @(posedge clk) begin
    rd_data_q <= rst ? '0 : rd_data_d;
    rd_busy_q <= rst ? 1'b0 : rd_busy_d;
  end
  assign rd_data_o = rd_data_q;
  assign rd_busy_o = rd_busy_q;
endmodule

// File: rtl/regfile_sync.sv
// regfile_sync: clocked register file with one write port, NUM_RD registered read ports and busy scoreboard.
//   clk, rst          clock, synchronous active-high reset (dominates write/reserve)
//   wr_en_i/wr_addr_i/wr_data_i   write port; a write clears the entry's busy bit
//   rsv_en_i/rsv_addr_i           reserve port; sets busy, wins over a same-address write
//   rd_addr_i         packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data_o         packed read data, port i at [i*DATA_W +: DATA_W], 1-cycle latency
//   rd_busy_o         busy bit of the entry read by each port, registered with rd_data_o
//   busy_vec_o        the busy register itself
//   Build option: REGFILE_ZERO_REG_EN hardwires entry 0 to zero.
module regfile_sync
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic                     rsv_en_i,
  input  logic [ADDR_W-1:0]        rsv_addr_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_busy_o,
  output logic [depth_of(ADDR_W)-1:0] busy_vec_o
);
  localparam int DEPTH = depth_of(ADDR_W);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic              wr_ok, rsv_ok;
  assign wr_ok  = wr_en_i && !(ZERO_REG && wr_addr_i == '0);
  assign rsv_ok = rsv_en_i && !(ZERO_REG && rsv_addr_i == '0);
  // Reserve is applied after the write so a new producer outlives a retiring one.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok) busy_d[wr_addr_i] = 1'b0;
    if (rsv_ok) busy_d[rsv_addr_i] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else begin
      busy_q <= busy_d;
      if (wr_ok) mem_q[wr_addr_i] <= wr_data_i;
    end
  end
  assign busy_vec_o = busy_q;
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port (
      .clk       (clk),
      .rst       (rst),
      .rd_addr_i (rd_addr_i[i*ADDR_W +: ADDR_W]),
      .wr_en_i   (wr_ok),
      .wr_addr_i (wr_addr_i),
      .wr_data_i (wr_data_i),
      .mem_data_i(mem_q[rd_addr_i[i*ADDR_W +: ADDR_W]]),
      .busy_nxt_i(busy_d[rd_addr_i[i*ADDR_W +: ADDR_W]]),
      .rd_data_o (rd_data_o[i*DATA_W +: DATA_W]),
      .rd_busy_o (rd_busy_o[i])
    );
  end
endmodule

// File: tb/tb_regfile_sync.sv
// tb_regfile_sync: directed vector table plus a fill/readback sequence for regfile_sync.
module tb_regfile_sync;
`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst, wr_en, rsv_en;
  logic [2:0]  wr_addr, rsv_addr;
  logic [31:0] wr_data;
  logic [5:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [7:0]  busy_vec;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  regfile_sync dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rsv_en_i  (rsv_en),
    .rsv_addr_i(rsv_addr),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data),
    .rd_busy_o (rd_busy),
    .busy_vec_o(busy_vec)
  );
  typedef struct {
    logic        rst, we;
    logic [2:0]  wa;
    logic [31:0] wd;
    logic        re;
    logic [2:0]  ra, a0, a1;
    logic [31:0] e0, e1;
    logic [1:0]  eb;
    logic [7:0]  ev;
  } vec_t;
  vec_t v[$];
  task automatic chk(input string n, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h exp=%h", n, idx, act, exp);
    end
  endtask
  task automatic drive(input logic r, input logic we, input logic [2:0] wa, input logic [31:0] wd,
                       input logic re, input logic [2:0] ra, input logic [2:0] a0, input logic [2:0] a1);
    @(negedge clk);
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
    rsv_en = re; rsv_addr = ra; rd_addr = {a1, a0};
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rsv_en = 1'b0; rsv_addr = '0; rd_addr = '0;
    //            rst we wa  wd            re ra a0 a1  e0                         e1            eb                 ev
    v.push_back('{1, 0, 0, 32'h0,         0, 0, 0, 0, 32'h0,                     32'h0,        2'b00,             8'h00});
    v.push_back('{0, 1, 3, 32'hDEADBEEF,  0, 0, 3, 0, 32'hDEADBEEF,              32'h0,        2'b00,             8'h00});
    v.push_back('{0, 0, 0, 32'h0,         0, 0, 3, 0, 32'hDEADBEEF,              32'h0,        2'b00,             8'h00});
    v.push_back('{1, 1, 3, 32'h11111111,  1, 3, 3, 3, 32'h0,                     32'h0,        2'b00,             8'h00});
    v.push_back('{0, 0, 0, 32'h0,         0, 0, 3, 3, 32'h0,                     32'h0,        2'b00,             8'h00});
    v.push_back('{0, 1, 5, 32'h12345678,  0, 0, 0, 0, 32'h0,                     32'h0,        2'b00,             8'h00});
    v.push_back('{0, 0, 0, 32'h0,         0, 0, 5, 0, 32'h12345678,              32'h0,        2'b00,             8'h00});
    v.push_back('{0, 1, 2, 32'hCAFEF00D,  0, 0, 5, 2, 32'h12345678,              32'hCAFEF00D, 2'b00,             8'h00});
    v.push_back('{0, 0, 0, 32'h0,         1, 4, 4, 2, 32'h0,                     32'hCAFEF00D, 2'b01,             8'h10});
    v.push_back('{0, 1, 4, 32'h7,         0, 0, 4, 4, 32'h7,                     32'h7,        2'b00,             8'h00});
    v.push_back('{0, 1, 4, 32'h9,         1, 4, 4, 0, 32'h9,                     32'h0,        2'b01,             8'h10});
    v.push_back('{0, 1, 1, 32'h11,        1, 6, 4, 1, 32'h9,                     32'h11,       2'b01,             8'h50});
    v.push_back('{0, 1, 6, 32'h66,        0, 0, 1, 6, 32'h11,                    32'h66,       2'b00,             8'h10});
    v.push_back('{0, 0, 0, 32'h0,         1, 7, 6, 1, 32'h66,                    32'h11,       2'b00,             8'h90});
    v.push_back('{0, 1, 0, 32'hFFFFFFFF,  1, 0, 0, 7, ZR ? 32'h0 : 32'hFFFFFFFF, 32'h0,        ZR ? 2'b10 : 2'b11, ZR ? 8'h90 : 8'h91});
    v.push_back('{0, 0, 0, 32'h0,         0, 0, 0, 0, ZR ? 32'h0 : 32'hFFFFFFFF, ZR ? 32'h0 : 32'hFFFFFFFF, ZR ? 2'b00 : 2'b11, ZR ? 8'h90 : 8'h91});
    v.push_back('{0, 1, 7, 32'hAB,        1, 2, 7, 2, 32'hAB,                    32'hCAFEF00D, 2'b10,             ZR ? 8'h14 : 8'h15});
    v.push_back('{1, 1, 5, 32'h5,         1, 5, 2, 7, 32'h0,                     32'h0,        2'b00,             8'h00});
    for (int i = 0; i < v.size(); i++) begin
      drive(v[i].rst, v[i].we, v[i].wa, v[i].wd, v[i].re, v[i].ra, v[i].a0, v[i].a1);
      chk("rd_data0", i, rd_data[31:0], v[i].e0);
      chk("rd_data1", i, rd_data[63:32], v[i].e1);
      chk("rd_busy", i, {30'b0, rd_busy}, {30'b0, v[i].eb});
      chk("busy_vec", i, {24'b0, busy_vec}, {24'b0, v[i].ev});
    end
    // Fill every entry, reserve a few, then read back on both ports in opposite orders.
    for (int k = 0; k < 8; k++) drive(1'b0, 1'b1, 3'(k), 32'h1000_0000 + k, 1'b0, 3'd0, 3'd0, 3'd0);
    drive(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 3'd3, 3'd0, 3'd0);
    chk("fill_busy_vec", 0, {24'b0, busy_vec}, 32'h08);
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 3'(k), 3'(7 - k));
      chk("fill_rd0", k, rd_data[31:0], (ZR && k == 0) ? 32'h0 : 32'h1000_0000 + k);
      chk("fill_rd1", k, rd_data[63:32], (ZR && k == 7) ? 32'h0 : 32'h1000_0007 - k);
      chk("fill_busy", k, {30'b0, rd_busy}, {30'b0, (7 - k) == 3, k == 3});
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
